wishbone_arbiter_2m: RTL and testbench
======================================

# wishbone_arbiter_2m

Two-master, one-slave Wishbone (classic, with registered-feedback cti/bte passthrough) arbiter in the `clk_sys` domain. It shares the SDRAM Wishbone slave port between the APF bridge write master, which carries data-slot loads from `clk_74a` via FIFO, and the SoC CPU/DMA master. Arbitration is round-robin and holds a grant for a whole `cyc` tenure, so bursts stay atomic. A watchdog terminates stalled slave cycles with `err`.

## Interface
Parameters:
- `TIMEOUT`, default 1024: stalled-strobe cycles before the watchdog fires. 0 disables the watchdog.
- `TW`, default `$clog2(TIMEOUT+1)`: watchdog counter width. Derived; do not override.

Ports:
- `clk_sys`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_addr`, `m1_addr`  in  30  word address per master
- `m0_data_write`, `m1_data_write`  in  32  write data
- `m0_sel`, `m1_sel`  in  4  byte lanes
- `m0_cyc`/`m0_stb`/`m0_we`, `m1_cyc`/`m1_stb`/`m1_we`  in  1 each  bus cycle, strobe, write enable
- `m0_cti`, `m1_cti`  in  3; `m0_bte`, `m1_bte`  in  2  burst type passthrough
- `m0_data_read`, `m1_data_read`  out  32  equal to `s_data_read` for both masters
- `m0_ack`, `m0_err`, `m1_ack`, `m1_err`  out  1 each  terminations, gated by grant
- `s_addr`  out  30; `s_data_write`  out  32; `s_sel`  out  4; `s_cti`  out  3; `s_bte`  out  2
- `s_cyc`, `s_stb`, `s_we`  out  1 each  slave request
- `s_ack`, `s_err`  in  1 each; `s_data_read`  in  32  slave response
- `grant`  out  2  one-hot current owner; 00 means idle

## Operation
- Registered state: `IDLE`, `G0`, `G1`; register `last` (0/1); watchdog counter `wd`, `TW` bits.
- Reset values: state `IDLE`, `last`=1 (master 0 wins the first tie), `wd`=0, `grant`=00.
- Slave outputs are a combinational mux on state:
  - `IDLE`: all `s_*` outputs are 0.
  - `G0`/`G1`: `s_*` follow the owning master's signals exactly.
- `m*_ack`/`m*_err`: equal `s_ack`/`s_err` for the owner, 0 for the other master, all 0 in `IDLE`.
- `IDLE` transitions:
  - only `m0_cyc` high → `G0`.
  - only `m1_cyc` high → `G1`.
  - both high → the master ≠ `last`.
  - neither high → stay in `IDLE`.
  - Set `last` to the chosen master on entry to its grant state.
- `Gx`: hold while `mx_cyc`=1 and the other master's `cyc` is ignored. When `mx_cyc`=0, go to `IDLE`, giving one dead cycle between tenures.
- Watchdog, active only when `TIMEOUT`≠0:
  - In `Gx` with `s_stb`=1 and `s_ack`=`s_err`=0: `wd` increments.
  - Any `s_ack` or `s_err`, `s_stb`=0, or leaving `Gx`: `wd` clears.
  - When `wd`==`TIMEOUT`: `mx_err`=1 for that cycle; `s_cyc`/`s_stb` are forced 0 that cycle; state → `IDLE`; `wd` clears. Any simultaneous `s_ack` is suppressed.
- Asserting `reset` mid-tenure immediately drops `s_cyc`/`s_stb`/`grant`. The owning master sees no ack and must retry.

## Timing
- Grant latency: `mx_cyc` rising in cycle N (state `IDLE`) → state `Gx` and `s_cyc` high in cycle N+1.
- Ack path is combinational, zero added latency: `s_ack` in cycle K gives `mx_ack` in cycle K.
- Release: `mx_cyc`=0 sampled in cycle K → `IDLE` in K+1 → the next owner earliest at K+2.
- Fairness: with both masters continuously requesting, tenures alternate 0,1,0,1,….
- Watchdog fires exactly `TIMEOUT` cycles after the first unanswered strobe cycle, counting that cycle as 0.
- `grant` is the registered state decode, no combinational input path.

## Test plan
- Reset, then `m0` single write `addr`=0x100, data 0xDEADBEEF; slave acks 2 cycles after `s_stb` → `s_cyc` high at cycle N+1, `s_addr`=0x100, `m0_ack` pulses once, `m1_ack`=0 throughout, `grant` returns to 00.
- `m0_cyc` and `m1_cyc` rise in the same cycle after reset → `grant`=01 first. After `m0` releases, `grant`=00 for 1 cycle, then 10.
- `m1` 4-beat incrementing burst (`cti`=010, last beat 111) while `m0` requests mid-burst → all 4 acks go to `m1`, `s_cti` mirrors `m1`, and `m0` is granted only after `m1_cyc` drops.
- `TIMEOUT`=8, slave never acks `m0` → `m0_err`=1 exactly 8 cycles after the first strobe, `s_cyc` is 0 that cycle, state is `IDLE` the next cycle, and a pending `m1` is granted after that.
- Assert `reset` during a `G1` tenure with `s_stb`=1 → all `s_*` outputs and `grant` go 0 immediately (asynchronously); after release, a tie between masters grants `m0`.

Source files
------------

// File: rtl/wishbone_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin tenure grants
// and a stalled-strobe watchdog that terminates hung slave cycles with err.
module wishbone_arbiter_2m #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_data_write,
  input  logic [3:0]  m0_sel,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  output logic [31:0] m0_data_read,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_data_write,
  input  logic [3:0]  m1_sel,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  output logic [31:0] m1_data_read,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [29:0] s_addr,
  output logic [31:0] s_data_write,
  output logic [3:0]  s_sel,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic [31:0] s_data_read,
  output logic [1:0]  grant
);

  // With TIMEOUT=0 the counter collapses to zero bits; keep one so it stays legal.
  localparam int WDW = (TW > 0) ? TW : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
  localparam bit WD_ENABLE = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           ownStb;
  logic           wdFire;

  always_comb begin
    ownStb = 1'b0;
    case (state_q)
      G0:      ownStb = m0_stb;
      G1:      ownStb = m1_stb;
      default: ownStb = 1'b0;
    endcase
  end

  assign wdFire = WD_ENABLE && (state_q != IDLE) && (wd_q == WD_LIMIT);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // On a tie, the master that did not own the previous tenure wins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = '0;
    case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = G0;
          last_d  = 1'b0;
        end else if (m1_cyc) begin
          state_d = G1;
          last_d  = 1'b1;
        end
      end
      G0: if (wdFire || !m0_cyc) state_d = IDLE;
      G1: if (wdFire || !m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (WD_ENABLE && (state_q != IDLE) && (state_d == state_q) && ownStb && !s_ack && !s_err)
      wd_d = wd_q + WDW'(1);
  end

  // A watchdog fire masks the strobe and any coincident ack, and reports err instead.
  always_comb begin
    s_addr       = '0;
    s_data_write = '0;
    s_sel        = '0;
    s_cti        = '0;
    s_bte        = '0;
    s_cyc        = 1'b0;
    s_stb        = 1'b0;
    s_we         = 1'b0;
    m0_ack       = 1'b0;
    m0_err       = 1'b0;
    m1_ack       = 1'b0;
    m1_err       = 1'b0;
    grant        = 2'b00;
    case (state_q)
      G0: begin
        s_addr       = m0_addr;
        s_data_write = m0_data_write;
        s_sel        = m0_sel;
        s_cti        = m0_cti;
        s_bte        = m0_bte;
        s_cyc        = m0_cyc & ~wdFire;
        s_stb        = m0_stb & ~wdFire;
        s_we         = m0_we;
        m0_ack       = s_ack & ~wdFire;
        m0_err       = s_err | wdFire;
        grant        = 2'b01;
      end
      G1: begin
        s_addr       = m1_addr;
        s_data_write = m1_data_write;
        s_sel        = m1_sel;
        s_cti        = m1_cti;
        s_bte        = m1_bte;
        s_cyc        = m1_cyc & ~wdFire;
        s_stb        = m1_stb & ~wdFire;
        s_we         = m1_we;
        m1_ack       = s_ack & ~wdFire;
        m1_err       = s_err | wdFire;
        grant        = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_data_read = s_data_read;
  assign m1_data_read = s_data_read;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed bench for wishbone_arbiter_2m: a vector table for arbitration and
// muxing, plus hand sequences for single write, burst, watchdog and reset.
module tb_wishbone_arbiter_2m;

  logic        clk_sys;
  logic        reset;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_data_write, m1_data_write;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [31:0] m0_data_read, m1_data_read;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [29:0] s_addr;
  logic [31:0] s_data_write;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        s_cyc, s_stb, s_we;
  logic        s_ack, s_err;
  logic [31:0] s_data_read;
  logic [1:0]  grant;

  int nChecks = 0;
  int nFails  = 0;

  wishbone_arbiter_2m #(.TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .m0_addr(m0_addr), .m0_data_write(m0_data_write), .m0_sel(m0_sel),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_data_read(m0_data_read), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_data_write(m1_data_write), .m1_sel(m1_sel),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_data_read(m1_data_read), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_data_write(s_data_write), .s_sel(s_sel), .s_cti(s_cti),
    .s_bte(s_bte), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_ack(s_ack), .s_err(s_err), .s_data_read(s_data_read), .grant(grant)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       c0, s0, c1, s1, ack, err;
    logic [1:0] eGrant;
    logic       eCyc, eAck0, eAck1, eErr0, eErr1;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkVec(logic [5:0] in, logic [1:0] g, logic [4:0] ex);
    vec_t v;
    {v.c0, v.s0, v.c1, v.s1, v.ack, v.err} = in;
    v.eGrant = g;
    {v.eCyc, v.eAck0, v.eAck1, v.eErr0, v.eErr1} = ex;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for the next rising edge, then drives a cycle's inputs and lets them settle.
  task automatic applyStimulus(input logic c0, s0, c1, s1, ack, err);
    @(posedge clk_sys);
    #1;
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1;
    s_ack = ack; s_err = err;
    #2;
  endtask

  initial begin
    int ackCount0, ackCount1;
    logic [29:0] eAddr;
    logic [31:0] eWdata;
    logic [3:0]  eSel;
    logic        eWe, eStb;
    logic [1:0]  eBte;

    reset = 1'b1;
    m0_addr = 30'h100; m0_data_write = 32'hDEADBEEF; m0_sel = 4'h3; m0_we = 1'b1;
    m0_cti = 3'b000; m0_bte = 2'b01;
    m1_addr = 30'h2AA; m1_data_write = 32'hCAFEF00D; m1_sel = 4'hC; m1_we = 1'b0;
    m1_cti = 3'b000; m1_bte = 2'b10;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_err = 0; s_data_read = 32'h0;

    vecs[0]  = mkVec(6'b000000, 2'b00, 5'b00000);
    vecs[1]  = mkVec(6'b110000, 2'b00, 5'b00000);
    vecs[2]  = mkVec(6'b110000, 2'b01, 5'b10000);
    vecs[3]  = mkVec(6'b111110, 2'b01, 5'b11000);
    vecs[4]  = mkVec(6'b001100, 2'b01, 5'b00000);
    vecs[5]  = mkVec(6'b001100, 2'b00, 5'b00000);
    vecs[6]  = mkVec(6'b111110, 2'b10, 5'b10100);
    vecs[7]  = mkVec(6'b111101, 2'b10, 5'b10001);
    vecs[8]  = mkVec(6'b110000, 2'b10, 5'b00000);
    vecs[9]  = mkVec(6'b110000, 2'b00, 5'b00000);
    vecs[10] = mkVec(6'b110010, 2'b01, 5'b11000);
    vecs[11] = mkVec(6'b000000, 2'b01, 5'b00000);
    vecs[12] = mkVec(6'b000000, 2'b00, 5'b00000);
    vecs[13] = mkVec(6'b111100, 2'b00, 5'b00000);
    vecs[14] = mkVec(6'b111110, 2'b10, 5'b10100);
    vecs[15] = mkVec(6'b110000, 2'b10, 5'b00000);
    vecs[16] = mkVec(6'b111100, 2'b00, 5'b00000);
    vecs[17] = mkVec(6'b111100, 2'b01, 5'b10000);
    vecs[18] = mkVec(6'b001100, 2'b01, 5'b00000);
    vecs[19] = mkVec(6'b000000, 2'b00, 5'b00000);

    repeat (2) @(posedge clk_sys);
    #1;
    checkOutput("resetGrant", 32'(grant), 32'h0);
    checkOutput("resetScyc", 32'(s_cyc), 32'h0);
    reset = 1'b0;

    // Arbitration, muxing and ack/err gating vectors
    for (int i = 0; i < 20; i++) begin
      s_data_read = 32'h1234_0000 + i;
      applyStimulus(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1, vecs[i].ack, vecs[i].err);
      eAddr = 30'h0; eWdata = 32'h0; eSel = 4'h0; eWe = 1'b0; eBte = 2'b00; eStb = 1'b0;
      if (vecs[i].eGrant == 2'b01) begin
        eAddr = m0_addr; eWdata = m0_data_write; eSel = m0_sel; eWe = m0_we; eBte = m0_bte; eStb = vecs[i].s0;
      end else if (vecs[i].eGrant == 2'b10) begin
        eAddr = m1_addr; eWdata = m1_data_write; eSel = m1_sel; eWe = m1_we; eBte = m1_bte; eStb = vecs[i].s1;
      end
      checkOutput($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].eGrant));
      checkOutput($sformatf("v%0d s_cyc", i), 32'(s_cyc), 32'(vecs[i].eCyc));
      checkOutput($sformatf("v%0d s_stb", i), 32'(s_stb), 32'(eStb));
      checkOutput($sformatf("v%0d m0_ack", i), 32'(m0_ack), 32'(vecs[i].eAck0));
      checkOutput($sformatf("v%0d m1_ack", i), 32'(m1_ack), 32'(vecs[i].eAck1));
      checkOutput($sformatf("v%0d m0_err", i), 32'(m0_err), 32'(vecs[i].eErr0));
      checkOutput($sformatf("v%0d m1_err", i), 32'(m1_err), 32'(vecs[i].eErr1));
      checkOutput($sformatf("v%0d s_addr", i), 32'(s_addr), 32'(eAddr));
      checkOutput($sformatf("v%0d s_wdata", i), s_data_write, eWdata);
      checkOutput($sformatf("v%0d s_sel", i), 32'(s_sel), 32'(eSel));
      checkOutput($sformatf("v%0d s_we", i), 32'(s_we), 32'(eWe));
      checkOutput($sformatf("v%0d s_bte", i), 32'(s_bte), 32'(eBte));
      checkOutput($sformatf("v%0d m0_rdata", i), m0_data_read, 32'h1234_0000 + i);
      checkOutput($sformatf("v%0d m1_rdata", i), m1_data_read, 32'h1234_0000 + i);
    end

    // Single m0 write, slave acks two cycles after the first strobe
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("wrGrantN", 32'(grant), 32'h0);
    checkOutput("wrScycN", 32'(s_cyc), 32'h0);
    ackCount0 = 0; ackCount1 = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 0, (k == 2), 0);
      if (k == 0) begin
        checkOutput("wrScycN1", 32'(s_cyc), 32'h1);
        checkOutput("wrAddr", 32'(s_addr), 32'h100);
        checkOutput("wrData", s_data_write, 32'hDEADBEEF);
      end
      checkOutput($sformatf("wrAck k%0d", k), 32'(m0_ack), 32'(k == 2));
      ackCount0 += int'(m0_ack);
      ackCount1 += int'(m1_ack);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      ackCount0 += int'(m0_ack);
      ackCount1 += int'(m1_ack);
    end
    checkOutput("wrAckCount0", 32'(ackCount0), 32'd1);
    checkOutput("wrAckCount1", 32'(ackCount1), 32'd0);
    checkOutput("wrGrantEnd", 32'(grant), 32'h0);

    // m1 4-beat burst with m0 requesting mid-burst
    m1_addr = 30'h400; m1_cti = 3'b010;
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("bGrantIdle", 32'(grant), 32'h0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b >= 1), (b >= 1), 1, 1, 1, 0);
      m1_addr = 30'h400 + 30'(b);
      m1_cti = (b == 3) ? 3'b111 : 3'b010;
      #1;
      checkOutput($sformatf("bGrant b%0d", b), 32'(grant), 32'h2);
      checkOutput($sformatf("bAck1 b%0d", b), 32'(m1_ack), 32'h1);
      checkOutput($sformatf("bAck0 b%0d", b), 32'(m0_ack), 32'h0);
      checkOutput($sformatf("bCti b%0d", b), 32'(s_cti), (b == 3) ? 32'h7 : 32'h2);
      checkOutput($sformatf("bAddr b%0d", b), 32'(s_addr), 32'h400 + b);
    end
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("bRelGrant", 32'(grant), 32'h2);
    checkOutput("bRelScyc", 32'(s_cyc), 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("bDeadGrant", 32'(grant), 32'h0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("bM0Grant", 32'(grant), 32'h1);
    checkOutput("bM0Addr", 32'(s_addr), 32'h100);
    m1_addr = 30'h2AA; m1_cti = 3'b000;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Watchdog: slave never acks m0, m1 waits
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 1, 1, 0, 0);
      checkOutput($sformatf("wdGrant k%0d", k), 32'(grant), 32'h1);
      checkOutput($sformatf("wdStb k%0d", k), 32'(s_stb), 32'h1);
      checkOutput($sformatf("wdErr k%0d", k), 32'(m0_err), 32'h0);
    end
    applyStimulus(1, 1, 1, 1, 1, 0);
    checkOutput("wdFireErr0", 32'(m0_err), 32'h1);
    checkOutput("wdFireAck0", 32'(m0_ack), 32'h0);
    checkOutput("wdFireScyc", 32'(s_cyc), 32'h0);
    checkOutput("wdFireSstb", 32'(s_stb), 32'h0);
    checkOutput("wdFireErr1", 32'(m1_err), 32'h0);
    applyStimulus(1, 1, 1, 1, 0, 0);
    checkOutput("wdIdle", 32'(grant), 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("wdM1Grant", 32'(grant), 32'h2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset during a G1 tenure, then a tie after release
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("rstPreGrant", 32'(grant), 32'h2);
    checkOutput("rstPreStb", 32'(s_stb), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rstScyc", 32'(s_cyc), 32'h0);
    checkOutput("rstSstb", 32'(s_stb), 32'h0);
    checkOutput("rstGrant", 32'(grant), 32'h0);
    checkOutput("rstSaddr", 32'(s_addr), 32'h0);
    applyStimulus(1, 1, 1, 1, 0, 0);
    checkOutput("rstHoldGrant", 32'(grant), 32'h0);
    reset = 1'b0;
    applyStimulus(1, 1, 1, 1, 0, 0);
    checkOutput("tieGrant0", 32'(grant), 32'h1);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("tieRelGrant", 32'(grant), 32'h1);
    checkOutput("tieRelScyc", 32'(s_cyc), 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("tieDead", 32'(grant), 32'h0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("tieGrant1", 32'(grant), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
